// File: rtl/vend_dispense_ctrl.sv
// Vending transaction sequencer: selection, coin credit, motor dispense with jam
// timeout, buzzer timing, change/refund pulses and a runtime price table.
module vend_dispense_ctrl #(
  parameter int unsigned         CREDIT_W      = 8,
  parameter logic [CREDIT_W-1:0] DEFAULT_PRICE = CREDIT_W'(25),
  parameter int unsigned         MOTOR_TIMEOUT = 1000,
  parameter int unsigned         BUZZ_CYCLES   = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sel_valid,
  input  logic [1:0]          sel_code,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                cancel,
  input  logic                ir_sensor,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [CREDIT_W-1:0] cfg_data,
  output logic [2:0]          state_o,
  output logic                red_led,
  output logic [2:0]          green_leds,
  output logic [3:0]          motor_en,
  output logic                buzzer,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                jam,
  output logic                busy
);

  localparam int unsigned TIMER_MAX = (MOTOR_TIMEOUT > BUZZ_CYCLES) ? MOTOR_TIMEOUT : BUZZ_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX) + 1;
  localparam logic [TIMER_W-1:0] MOTOR_LAST = TIMER_W'(MOTOR_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BUZZ_LAST  = TIMER_W'(BUZZ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_PAYMENT  = 3'd2,
    S_DISPENSE = 3'd3,
    S_COMPLETE = 3'd4,
    S_REFUND   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [1:0]          slot_q, slot_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CREDIT_W-1:0] price_reg_q [4];
  logic [CREDIT_W-1:0] price_reg_d [4];
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                jam_q, jam_d;

  logic [CREDIT_W:0]   coin_sum_c;
  logic [CREDIT_W-1:0] credit_sat_c;
  logic [CREDIT_W-1:0] change_c;

  // Saturating credit add and change due against the snapshot price
  assign coin_sum_c   = {1'b0, credit_q} + {1'b0, coin_value};
  assign credit_sat_c = coin_sum_c[CREDIT_W] ? '1 : coin_sum_c[CREDIT_W-1:0];
  assign change_c     = credit_q - price_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      price_q         <= '0;
      slot_q          <= '0;
      timer_q         <= '0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      jam_q           <= 1'b0;
      for (int i = 0; i < 4; i++) price_reg_q[i] <= DEFAULT_PRICE;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      price_q         <= price_d;
      slot_q          <= slot_d;
      timer_q         <= timer_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      jam_q           <= jam_d;
      for (int i = 0; i < 4; i++) price_reg_q[i] <= price_reg_d[i];
    end
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    price_d         = price_q;
    slot_d          = slot_q;
    timer_d         = timer_q;
    change_valid_d  = 1'b0;
    change_amount_d = '0;
    jam_d           = 1'b0;
    for (int i = 0; i < 4; i++) price_reg_d[i] = price_reg_q[i];
    if (cfg_we) price_reg_d[cfg_addr] = cfg_data;

    case (state_q)
      S_IDLE: begin
        credit_d = '0;
        timer_d  = '0;
        if (start) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (sel_valid) begin
          slot_d  = sel_code;
          price_d = price_reg_q[sel_code];
          state_d = S_PAYMENT;
        end
      end
      S_PAYMENT: begin
        if (coin_valid) credit_d = credit_sat_c;
        // Refund reports the credit including a coin landing with cancel
        if (cancel) begin
          state_d         = S_REFUND;
          change_valid_d  = (credit_d != '0);
          change_amount_d = credit_d;
        end else if (credit_q >= price_q) begin
          state_d = S_DISPENSE;
          timer_d = '0;
        end
      end
      S_DISPENSE: begin
        timer_d = timer_q + TIMER_W'(1);
        if (ir_sensor) begin
          state_d         = S_COMPLETE;
          timer_d         = '0;
          change_valid_d  = (change_c != '0);
          change_amount_d = change_c;
        end else if (timer_q == MOTOR_LAST) begin
          state_d         = S_REFUND;
          jam_d           = 1'b1;
          change_valid_d  = (credit_q != '0);
          change_amount_d = credit_q;
        end
      end
      S_COMPLETE: begin
        timer_d = timer_q + TIMER_W'(1);
        if (timer_q == BUZZ_LAST) state_d = S_IDLE;
      end
      S_REFUND: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign state_o       = state_q;
  assign red_led       = (state_q == S_IDLE);
  assign green_leds    = (state_q == S_SELECT)  ? 3'b111 :
                         (state_q == S_PAYMENT) ? 3'b011 : 3'b000;
  assign motor_en      = (state_q == S_DISPENSE) ? (4'b0001 << slot_q) : 4'b0000;
  assign buzzer        = (state_q == S_COMPLETE);
  assign busy          = (state_q != S_IDLE);
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign jam           = jam_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: vector table, directed corner sequences and a
// randomized transaction run checked against a rule-level model.
module tb_vend_dispense_ctrl;

  localparam int BUZZ = 50;
  localparam int MTO  = 1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, sel_valid, coin_valid, cancel, ir_sensor, cfg_we;
  logic [1:0] sel_code, cfg_addr;
  logic [7:0] coin_value, cfg_data;
  logic [2:0] state_o;
  logic       red_led, buzzer, change_valid, jam, busy;
  logic [2:0] green_leds;
  logic [3:0] motor_en;
  logic [7:0] change_amount;

  int n_checks = 0;
  int n_fail   = 0;
  int mp[4];

  vend_dispense_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .sel_valid(sel_valid), .sel_code(sel_code),
    .coin_valid(coin_valid), .coin_value(coin_value), .cancel(cancel), .ir_sensor(ir_sensor),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .state_o(state_o),
    .red_led(red_led), .green_leds(green_leds), .motor_en(motor_en), .buzzer(buzzer),
    .change_valid(change_valid), .change_amount(change_amount), .jam(jam), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [22:0] obs;
  assign obs = {state_o, red_led, green_leds, motor_en, buzzer, change_valid, change_amount, jam, busy};

  typedef struct {
    logic       st, sv;
    logic [1:0] sc;
    logic       cv;
    logic [7:0] cval;
    logic       cn, ir;
    logic [2:0] est;
    logic [1:0] eslot;
    logic       ecv;
    logic [7:0] eca;
  } vec_t;

  vec_t tbl[14];

  // Expected output bundle built from the state-to-output rules
  function automatic logic [22:0] exp_vec(input logic [2:0] st, input logic [1:0] slot,
                                          input logic cv, input logic [7:0] ca, input logic jm);
    logic       red, buz, bsy;
    logic [2:0] grn;
    logic [3:0] mot;
    red = (st == 3'd0);
    grn = (st == 3'd1) ? 3'b111 : (st == 3'd2) ? 3'b011 : 3'b000;
    mot = (st == 3'd3) ? (4'b0001 << slot) : 4'b0000;
    buz = (st == 3'd4);
    bsy = (st != 3'd0);
    return {st, red, grn, mot, buz, cv, ca, jm, bsy};
  endfunction

  task automatic check(input string nm, input logic [22:0] act, input logic [22:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic step(input logic st, input logic sv, input logic [1:0] sc, input logic cv,
                      input logic [7:0] cval, input logic cn, input logic ir);
    start = st; sel_valid = sv; sel_code = sc; coin_valid = cv; coin_value = cval;
    cancel = cn; ir_sensor = ir;
    @(posedge clk);
    #1;
    start = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; cancel = 1'b0; ir_sensor = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_addr = 2'(a); cfg_data = 8'(d); cfg_we = 1'b1;
    idle_step();
    mp[a] = d;
  endtask

  // Steps until IDLE (bounded), returning how many observed cycles had the buzzer on
  task automatic wait_idle(input string nm, output int buzz_cnt);
    buzz_cnt = 0;
    for (int i = 0; i < 300 && state_o != 3'd0; i++) begin
      if (buzzer) buzz_cnt++;
      idle_step();
    end
    check(nm, obs, exp_vec(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
  endtask

  // Start, select a slot, pay enough and reach DISPENSE
  task automatic to_dispense(input logic [1:0] slot, input logic [7:0] coin, input string nm);
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, slot, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, coin, 1'b0, 1'b0);
    idle_step();
    check(nm, obs, exp_vec(3'd3, slot, 1'b0, 8'd0, 1'b0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int price, credit, newc, coin, d;
    logic [1:0] slot;
    logic [2:0] est;
    logic ecv, cn, done, refund;
    logic [7:0] eca;

    tbl[0]  = '{1'b0, 1'b1, 2'd1, 1'b1, 8'd10, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 8'd0,  1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b1, 8'd10, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 8'd5,  1'b1, 1'b0, 3'd5, 2'd0, 1'b1, 8'd15};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 1'b0, 8'd0,  1'b0, 1'b0, 3'd2, 2'd2, 1'b0, 8'd0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'd10, 1'b0, 1'b0, 3'd2, 2'd2, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'd15, 1'b0, 1'b0, 3'd2, 2'd2, 1'b0, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0, 3'd3, 2'd2, 1'b0, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b1, 8'd7,  1'b1, 1'b1, 3'd4, 2'd2, 1'b0, 8'd0};

    start = 1'b0; sel_valid = 1'b0; sel_code = 2'd0; coin_valid = 1'b0; coin_value = 8'd0;
    cancel = 1'b0; ir_sensor = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) mp[i] = 25;
    #12;
    check("reset_state", obs, exp_vec(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].st, tbl[i].sv, tbl[i].sc, tbl[i].cv, tbl[i].cval, tbl[i].cn, tbl[i].ir);
      check($sformatf("tbl_%0d", i), obs, exp_vec(tbl[i].est, tbl[i].eslot, tbl[i].ecv, tbl[i].eca, 1'b0));
    end
    wait_idle("tbl_idle", bc);
    check_int("buzz_len", bc, BUZZ);

    // Overpay: 20+20 against 25 returns 15 change as a single pulse
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd20, 1'b0, 1'b0);
    check("chg_pay", obs, exp_vec(3'd2, 2'd1, 1'b0, 8'd0, 1'b0));
    idle_step();
    check("chg_disp", obs, exp_vec(3'd3, 2'd1, 1'b0, 8'd0, 1'b0));
    step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("chg_pulse", obs, exp_vec(3'd4, 2'd1, 1'b1, 8'd15, 1'b0));
    idle_step();
    check("chg_single", obs, exp_vec(3'd4, 2'd1, 1'b0, 8'd0, 1'b0));
    wait_idle("chg_idle", bc);

    // Jam: ir held low for the whole timeout window
    to_dispense(2'd3, 8'd30, "jam_disp");
    for (int i = 1; i < MTO; i++) idle_step();
    check("jam_last_disp", obs, exp_vec(3'd3, 2'd3, 1'b0, 8'd0, 1'b0));
    idle_step();
    check("jam_refund", obs, exp_vec(3'd5, 2'd3, 1'b1, 8'd30, 1'b1));
    idle_step();
    check("jam_idle", obs, exp_vec(3'd0, 2'd3, 1'b0, 8'd0, 1'b0));

    // Drop detected on the final timeout cycle wins over jam
    to_dispense(2'd0, 8'd30, "edge_disp");
    for (int i = 1; i < MTO; i++) idle_step();
    step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("edge_complete", obs, exp_vec(3'd4, 2'd0, 1'b1, 8'd5, 1'b0));
    wait_idle("edge_idle", bc);

    // Price rewrite mid-transaction keeps the snapshot
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0);
    cfg_addr = 2'd1; cfg_data = 8'd40; cfg_we = 1'b1; mp[1] = 40;
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd25, 1'b0, 1'b0);
    idle_step();
    check("snap_disp", obs, exp_vec(3'd3, 2'd1, 1'b0, 8'd0, 1'b0));
    step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("snap_exact", obs, exp_vec(3'd4, 2'd1, 1'b0, 8'd0, 1'b0));
    wait_idle("snap_idle", bc);
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd25, 1'b0, 1'b0);
    idle_step();
    check("new_price_wait", obs, exp_vec(3'd2, 2'd1, 1'b0, 8'd0, 1'b0));
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd15, 1'b0, 1'b0);
    idle_step();
    check("new_price_disp", obs, exp_vec(3'd3, 2'd1, 1'b0, 8'd0, 1'b0));
    step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    wait_idle("new_price_idle", bc);

    // Saturation: 100+100+100 with cancel refunds 255
    cfg_write(2, 255);
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd2, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd100, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 8'd100, 1'b1, 1'b0);
    check("sat_refund", obs, exp_vec(3'd5, 2'd2, 1'b1, 8'd255, 1'b0));
    idle_step();

    // Zero price dispenses on the first payment cycle, no change
    cfg_write(3, 0);
    step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 1'b0, 8'd0, 1'b0, 1'b0);
    idle_step();
    check("free_disp", obs, exp_vec(3'd3, 2'd3, 1'b0, 8'd0, 1'b0));
    step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
    check("free_nochg", obs, exp_vec(3'd4, 2'd3, 1'b0, 8'd0, 1'b0));
    wait_idle("free_idle", bc);

    // Async reset mid-dispense
    cfg_write(0, 25);
    to_dispense(2'd0, 8'd30, "rst_disp");
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", obs, exp_vec(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) mp[i] = 25;
    @(posedge clk);
    #1;

    // Randomized transactions against the rule model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 80)));
        check("rnd_cfg", obs, exp_vec(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
      end
      step(1'b1, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      check("rnd_start", obs, exp_vec(3'd1, 2'd0, 1'b0, 8'd0, 1'b0));
      slot = 2'($urandom_range(0, 3));
      step(1'b0, 1'b1, slot, 1'b0, 8'd0, 1'b0, 1'b0);
      check("rnd_sel", obs, exp_vec(3'd2, slot, 1'b0, 8'd0, 1'b0));
      price = mp[slot];
      credit = 0; done = 1'b0; refund = 1'b0;
      for (int j = 0; j < 80 && !done; j++) begin
        coin = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0;
        cn = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 7) == 0) begin
          d = int'($urandom_range(0, 3));
          cfg_addr = 2'(d); cfg_data = 8'($urandom_range(0, 80)); cfg_we = 1'b1;
          mp[d] = int'(cfg_data);
        end
        newc = (credit + coin > 255) ? 255 : credit + coin;
        ecv = 1'b0; eca = 8'd0;
        if (cn) begin
          est = 3'd5; ecv = (newc != 0); eca = 8'(newc); done = 1'b1; refund = 1'b1;
        end else if (credit >= price) begin
          est = 3'd3; done = 1'b1;
        end else begin
          est = 3'd2;
        end
        step(1'b0, 1'b0, 2'd0, coin != 0, 8'(coin), cn, 1'b0);
        check("rnd_pay", obs, exp_vec(est, slot, ecv, eca, 1'b0));
        credit = newc;
      end
      if (!done) check_int("rnd_pay_bound", 0, 1);
      if (refund) begin
        idle_step();
        check("rnd_ref_idle", obs, exp_vec(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
      end else if (done) begin
        d = int'($urandom_range(0, 4));
        for (int k = 0; k < d; k++) begin
          step(1'b0, 1'b0, 2'd0, 1'b1, 8'($urandom_range(1, 60)), $urandom_range(0, 1) == 1, 1'b0);
          check("rnd_disp", obs, exp_vec(3'd3, slot, 1'b0, 8'd0, 1'b0));
        end
        step(1'b0, 1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        check("rnd_complete", obs, exp_vec(3'd4, slot, (credit - price) != 0, 8'(credit - price), 1'b0));
        for (int k = 1; k < BUZZ; k++) begin
          step(1'b0, $urandom_range(0, 1) == 1, 2'd1, $urandom_range(0, 1) == 1, 8'd9,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
          check("rnd_buzz", obs, exp_vec(3'd4, slot, 1'b0, 8'd0, 1'b0));
        end
        idle_step();
        check("rnd_end_idle", obs, exp_vec(3'd0, 2'd0, 1'b0, 8'd0, 1'b0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Transaction sequencer for the vending datapath: start button, slot selection, coin credit, motor dispense, change and refund. Owns the per-slot price table (runtime configurable), credit accumulation, one-hot slot motor drive with jam timeout, buzzer timing and status LEDs. Sits between the front-panel inputs (button, keypad decoder, coin acceptor, IR drop sensor) and the actuators.

Parameters:
CREDIT_W, 8, width of credit, price and change values.
DEFAULT_PRICE, 8'd25, reset value of all four price registers.
MOTOR_TIMEOUT, 1000, DISPENSE cycles allowed before jam is declared (>=2).
BUZZ_CYCLES, 50, COMPLETE buzzer duration in cycles (>=1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  single-cycle pulse; begins a transaction from IDLE
sel_valid  in  1  single-cycle pulse; sel_code is valid
sel_code  in  2  slot number 0-3
coin_valid  in  1  single-cycle pulse; coin_value is valid
coin_value  in  CREDIT_W  value of the inserted coin
cancel  in  1  single-cycle pulse; abort the transaction
ir_sensor  in  1  item-drop detect, level, already synchronised
cfg_we  in  1  price register write strobe
cfg_addr  in  2  price register index
cfg_data  in  CREDIT_W  price value
state_o  out  3  current state encoding
red_led  out  1  high in IDLE
green_leds  out  3  3'b111 in SELECT, 3'b011 in PAYMENT, else 0
motor_en  out  4  one-hot motor for the latched slot, DISPENSE only
buzzer  out  1  high in COMPLETE
change_valid  out  1  single-cycle pulse
change_amount  out  CREDIT_W  change/refund value, valid with change_valid, else 0
jam  out  1  single-cycle pulse on motor timeout
busy  out  1  state != IDLE

Behaviour:
- States: IDLE=0, SELECT=1, PAYMENT=2, DISPENSE=3, COMPLETE=4, REFUND=5. Moore LED, motor and buzzer outputs are decoded from the registered state. change_valid, change_amount and jam are registered.
- Reset (async): state IDLE, credit 0, timer 0, all price regs DEFAULT_PRICE, change_valid/change_amount/jam 0. red_led=1; all other outputs 0. Reset mid-DISPENSE drops motor_en immediately and loses credit.
- IDLE: start -> SELECT. Credit and timer cleared on entry. coin_valid, sel_valid and cancel are ignored.
- SELECT: sel_valid latches slot=sel_code and price=price_reg[sel_code] (snapshot), then -> PAYMENT. cancel -> IDLE with no change pulse. If both arrive in the same cycle, cancel wins.
- PAYMENT: coin_valid adds credit += coin_value, saturating at 2^CREDIT_W-1.
  - Compare uses registered credit: if credit >= price -> DISPENSE. Credit reaches price one cycle after the completing coin. price=0 goes to DISPENSE on the first PAYMENT cycle.
  - cancel -> REFUND. A coin arriving in the same cycle as cancel is added and included in the refund. cancel takes priority over the credit>=price transition.
- DISPENSE: motor_en = 1<<slot. Timer counts from 0 each cycle.
  - ir_sensor=1 -> COMPLETE.
  - timer == MOTOR_TIMEOUT-1 with ir_sensor=0 -> REFUND, jam pulses 1 cycle. ir_sensor=1 in that same cycle wins (COMPLETE, no jam).
  - coin_valid and cancel are ignored.
- COMPLETE: on the entry cycle, if credit-price != 0, change_valid=1 and change_amount=credit-price. No pulse if exact. buzzer high for exactly BUZZ_CYCLES cycles, then -> IDLE.
- REFUND: one cycle. change_valid=1 and change_amount=credit (full credit), then -> IDLE. If credit=0, no pulse.
- Config: cfg_we writes price_reg[cfg_addr]=cfg_data in any state. The in-flight transaction keeps its snapshot price.
- Timing: a start pulse results in busy=1 on the next cycle.

Test Plan:
- Reset, start, sel_code=2, coins 10 and 15 (price 25) -> PAYMENT->DISPENSE one cycle after the second coin; motor_en=4'b0100; ir_sensor=1 -> COMPLETE, no change pulse, buzzer high 50 cycles, then IDLE with red_led=1.
- Price 25, coins 20 and 20 -> credit 40; after ir_sensor, change_valid 1 cycle with change_amount=15.
- Coin 10 in PAYMENT, then cancel+coin 5 in the same cycle -> REFUND; change_amount=15, IDLE on the next cycle.
- DISPENSE with ir_sensor held 0 -> jam pulse at cycle 999 of DISPENSE, full-credit refund, motor_en=0 on the following cycle. Repeat with ir_sensor=1 at cycle 999 -> COMPLETE, no jam.
- cfg write slot1=40 during PAYMENT of slot1 (snapshot 25), coin 25 -> dispenses. The next transaction on slot1 needs 40.
- Coins totalling 300 with CREDIT_W=8 -> credit saturates at 255. Async reset asserted mid-DISPENSE -> motor_en=0 immediately, state_o=0.
